screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 8: frame_ticks each intro animation step is held (legal range 1..255).
REQ-002 SHALL have parameter RESULT_FRAMES, default 60: minimum frame_ticks spent in RESULTS before a key press is accepted (legal range 1..255).
REQ-003 SHALL have port Clk, input, 1: the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame (vsync).
REQ-006 SHALL have port J_Press, input, 1: key level, already synchronous to Clk.
REQ-007 SHALL have port song_done, input, 1: one-cycle pulse when the chart ends.
REQ-008 SHALL have port screen, output, 2: 00 TITLE, 01 INTRO, 10 PLAY or PAUSED, 11 RESULTS.
REQ-009 SHALL have port frame, output, 2: start-screen sprite select.
REQ-010 SHALL have port game_start, output, 1: one-cycle pulse on entry to PLAY from INTRO.
REQ-011 SHALL have port game_run, output, 1: high while the song and scoring advance.

Function
REQ-012 SHALL detect a press as J_Press=1 in the current cycle with J_Press=0 in the previous cycle, the previous value being held in a register; a held key SHALL yield exactly one press.
REQ-013 SHALL implement states TITLE, INTRO, PLAY, PAUSED and RESULTS; every output SHALL be a registered output or a decode of registered state.
REQ-014 In TITLE: frame=01, game_run=0; a press SHALL move to INTRO with step=0 and hold counter=0.
REQ-015 In INTRO: frame=10 at steps 0 and 1, frame=11 at step 2; the hold counter SHALL increment on each frame_tick, and when it reaches HOLD_FRAMES-1 on a tick it SHALL clear and step SHALL advance.
REQ-016 On the tick that ends step 2, the block SHALL enter PLAY and assert game_start for exactly that next cycle; presses in INTRO SHALL be ignored.
REQ-017 In PLAY: frame=00 and game_run=1; song_done SHALL move to RESULTS and clear the hold counter.
REQ-018 In RESULTS: frame=00 and game_run=0; the counter SHALL saturate at RESULT_FRAMES; a press SHALL move to TITLE only once the counter is saturated, and earlier presses SHALL be ignored.
REQ-019 When song_done and a press coincide in PLAY, song_done SHALL win.
REQ-020 A frame_tick arriving in the same cycle as a state entry SHALL NOT be counted in the new state.

Reset
REQ-021 While Reset=0, the block SHALL be in TITLE with screen=00, frame=01, game_start=0, game_run=0, step=0, counter=0 and the previous-key register=1, so that a key held through reset does not register a press.
REQ-022 Reset asserted mid-INTRO or mid-PLAY SHALL abort immediately with no game_start pulse; the first cycle after release SHALL already be TITLE.

Configuration
REQ-023 With macro SCREEN_SEQUENCER_PAUSE_EN defined, a press in PLAY SHALL enter PAUSED (screen=10, game_run=0, frame=00), and a press in PAUSED SHALL return to PLAY with no game_start pulse.
REQ-024 With SCREEN_SEQUENCER_PAUSE_EN undefined, the PAUSED state SHALL NOT exist and presses in PLAY SHALL be ignored.
REQ-025 song_done while in PAUSED (when the macro is defined) SHALL move to RESULTS.

Verification
REQ-026 Reset release, J low, 10 ticks -> screen=00, frame=01, game_run=0 throughout.
REQ-027 HOLD_FRAMES=2, press then 6 ticks -> frame 10,10,10,10,11,11 per tick, then screen=10 and a single-cycle game_start.
REQ-028 In PLAY, song_done and a press in the same cycle -> screen=11, game_run=0; press after 59 ticks ignored, press after 60 ticks -> screen=00.
REQ-029 J held high across reset release and into TITLE -> stays TITLE; release then press -> INTRO.
REQ-030 Macro defined, press in PLAY -> game_run=0, press again -> game_run=1 with game_start=0; macro undefined -> game_run stays 1.
REQ-031 Reset pulsed low at INTRO step 1 -> TITLE on the next cycle, and game_start never asserted.

Source files
------------

// File: rtl/screen_sequencer.sv
// Game screen sequencer: TITLE -> INTRO animation -> PLAY (optional PAUSED, SCREEN_SEQUENCER_PAUSE_EN) -> RESULTS.
// Latency: outputs registered, reflect an input one Clk after it is seen; game_start is a one-cycle pulse.
// Backpressure: none; every input is sampled every cycle and never stalled.
module screen_sequencer #(
    parameter int HOLD_FRAMES   = 8,
    parameter int RESULT_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       J_Press,
    input  logic       song_done,
    output logic [1:0] screen,
    output logic [1:0] frame,
    output logic       game_start,
    output logic       game_run
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] RES_SAT   = 8'(RESULT_FRAMES);

`ifdef SCREEN_SEQUENCER_PAUSE_EN
    typedef enum logic [2:0] {S_TITLE, S_INTRO, S_PLAY, S_PAUSED, S_RESULTS} state_t;
`else
    typedef enum logic [2:0] {S_TITLE, S_INTRO, S_PLAY, S_RESULTS} state_t;
`endif

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [7:0] cnt_q, cnt_d;
    logic       j_prev_q;
    logic       press;
    logic       start_d;
    logic [1:0] screen_d, frame_d;
    logic       run_d;

    assign press = J_Press & ~j_prev_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (press) begin
                    state_d = S_INTRO;
                    step_d  = 2'd0;
                    cnt_d   = 8'd0;
                end
            end
            S_INTRO: begin
                if (frame_tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = 8'd0;
                        if (step_q == 2'd2) begin
                            state_d = S_PLAY;
                            step_d  = 2'd0;
                            start_d = 1'b1;
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                // song_done has priority over a simultaneous press
                if (song_done) begin
                    state_d = S_RESULTS;
                    cnt_d   = 8'd0;
                end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
                else if (press) begin
                    state_d = S_PAUSED;
                end
`endif
            end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
            S_PAUSED: begin
                if (song_done) begin
                    state_d = S_RESULTS;
                    cnt_d   = 8'd0;
                end else if (press) begin
                    state_d = S_PLAY;
                end
            end
`endif
            S_RESULTS: begin
                if (press && cnt_q == RES_SAT) begin
                    state_d = S_TITLE;
                    cnt_d   = 8'd0;
                end else if (frame_tick && cnt_q != RES_SAT) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_TITLE;
                step_d  = 2'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        screen_d = 2'b00;
        frame_d  = 2'b00;
        run_d    = 1'b0;
        case (state_d)
            S_TITLE: frame_d = 2'b01;
            S_INTRO: begin
                screen_d = 2'b01;
                frame_d  = (step_d == 2'd2) ? 2'b11 : 2'b10;
            end
            S_PLAY: begin
                screen_d = 2'b10;
                run_d    = 1'b1;
            end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
            S_PAUSED: screen_d = 2'b10;
`endif
            S_RESULTS: screen_d = 2'b11;
            default: frame_d = 2'b01;
        endcase
    end

    // Previous-key register resets high so a key held through reset is not a press
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_TITLE;
            step_q     <= 2'd0;
            cnt_q      <= 8'd0;
            j_prev_q   <= 1'b1;
            screen     <= 2'b00;
            frame      <= 2'b01;
            game_start <= 1'b0;
            game_run   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            j_prev_q   <= J_Press;
            screen     <= screen_d;
            frame      <= frame_d;
            game_start <= start_d;
            game_run   <= run_d;
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomized plus directed bench for screen_sequencer against a tick-counting reference model.
module tb_screen_sequencer;

    localparam int HOLD = 2;
    localparam int RES  = 60;

    localparam int M_TITLE   = 0;
    localparam int M_INTRO   = 1;
    localparam int M_PLAY    = 2;
    localparam int M_PAUSED  = 3;
    localparam int M_RESULTS = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       J_Press = 1'b0;
    logic       song_done = 1'b0;
    logic [1:0] screen, frame;
    logic       game_start, game_run;

    int checks = 0;
    int errors = 0;

    int   m_mode;
    logic m_prev_j;
    int   m_intro_ticks;
    int   m_res_ticks;
    logic m_gs;

    screen_sequencer #(.HOLD_FRAMES(HOLD), .RESULT_FRAMES(RES)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .J_Press(J_Press),
        .song_done(song_done), .screen(screen), .frame(frame),
        .game_start(game_start), .game_run(game_run)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_TITLE; m_prev_j = 1'b1; m_intro_ticks = 0; m_res_ticks = 0; m_gs = 1'b0;
    endtask

    task automatic model_step(input logic t, input logic j, input logic d);
        logic press;
        press = j && !m_prev_j;
        m_prev_j = j;
        m_gs = 1'b0;
        case (m_mode)
            M_TITLE: if (press) begin m_mode = M_INTRO; m_intro_ticks = 0; end
            M_INTRO: if (t) begin
                m_intro_ticks++;
                if (m_intro_ticks == 3 * HOLD) begin m_mode = M_PLAY; m_gs = 1'b1; end
            end
            M_PLAY: begin
                if (d) begin m_mode = M_RESULTS; m_res_ticks = 0; end
`ifdef SCREEN_SEQUENCER_PAUSE_EN
                else if (press) m_mode = M_PAUSED;
`endif
            end
            M_PAUSED: begin
                if (d) begin m_mode = M_RESULTS; m_res_ticks = 0; end
                else if (press) m_mode = M_PLAY;
            end
            default: begin
                if (press && m_res_ticks >= RES) m_mode = M_TITLE;
                else if (t && m_res_ticks < RES) m_res_ticks++;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [1:0] e_scr, e_frm;
        e_scr = (m_mode == M_TITLE) ? 2'b00 : (m_mode == M_INTRO) ? 2'b01 :
                (m_mode == M_RESULTS) ? 2'b11 : 2'b10;
        e_frm = (m_mode == M_TITLE) ? 2'b01 :
                (m_mode == M_INTRO) ? ((m_intro_ticks / HOLD) < 2 ? 2'b10 : 2'b11) : 2'b00;
        chk("screen", 8'(screen), 8'(e_scr));
        chk("frame", 8'(frame), 8'(e_frm));
        chk("game_run", 8'(game_run), 8'(m_mode == M_PLAY));
        chk("game_start", 8'(game_start), 8'(m_gs));
    endtask

    // Inputs are driven after a negedge; outputs are checked at the following negedge.
    task automatic cyc(input logic t, input logic j, input logic d);
        frame_tick = t; J_Press = j; song_done = d;
        model_step(t, j, d);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic apply_reset(input logic j);
        Reset = 1'b0; J_Press = j; frame_tick = 1'b0; song_done = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge Clk);
        @(negedge Clk);
        compare_all();
        Reset = 1'b1;
    endtask

    task automatic go_play();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 3 * HOLD; i++) cyc(1, 0, 0);
    endtask

    initial begin
        logic [1:0] exp_frm [6];
        logic       jl;
        exp_frm = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        model_reset();
        @(negedge Clk);
        apply_reset(1'b0);

        // Idle title screen with ticks
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0);
            chk("idle_screen", 8'(screen), 8'h0);
            chk("idle_frame", 8'(frame), 8'h1);
        end

        // Intro animation frames, one sample per tick
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("intro_frame", 8'(frame), 8'(exp_frm[i]));
            cyc(1, 0, 0);
        end
        chk("play_screen", 8'(screen), 8'h2);
        chk("start_pulse", 8'(game_start), 8'h1);
        cyc(0, 0, 0);
        chk("start_gone", 8'(game_start), 8'h0);

        // song_done beats a simultaneous press; results lockout
        cyc(0, 1, 1);
        chk("res_screen", 8'(screen), 8'h3);
        chk("res_run", 8'(game_run), 8'h0);
        cyc(0, 0, 0);
        for (int i = 0; i < RES - 1; i++) cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("early_press", 8'(screen), 8'h3);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("late_press", 8'(screen), 8'h0);
        cyc(0, 0, 0);

        // Key held through reset
        apply_reset(1'b1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0);
        chk("held_title", 8'(screen), 8'h0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("held_then_press", 8'(screen), 8'h1);
        cyc(0, 0, 0);
        for (int i = 0; i < 3 * HOLD; i++) cyc(1, 0, 0);

        // Press in PLAY
        cyc(0, 0, 0);
        cyc(0, 1, 0);
`ifdef SCREEN_SEQUENCER_PAUSE_EN
        chk("pause_run", 8'(game_run), 8'h0);
        chk("pause_screen", 8'(screen), 8'h2);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("resume_run", 8'(game_run), 8'h1);
        chk("resume_start", 8'(game_start), 8'h0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        chk("paused_done", 8'(screen), 8'h3);
`else
        chk("nopause_run", 8'(game_run), 8'h1);
`endif

        // Reset mid-intro at step 1
        apply_reset(1'b0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < HOLD; i++) cyc(1, 0, 0);
        Reset = 1'b0;
        #1;
        chk("abort_screen", 8'(screen), 8'h0);
        chk("abort_start", 8'(game_start), 8'h0);
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3 * HOLD; i++) begin
            cyc(1, 0, 0);
            chk("after_abort", 8'(screen), 8'h0);
            chk("no_start", 8'(game_start), 8'h0);
        end

        // Reset mid-play
        go_play();
        cyc(0, 0, 0);
        apply_reset(1'b0);
        cyc(0, 0, 0);

        // Randomized run
        jl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset(jl);
            end else begin
                if ($urandom_range(0, 3) == 0) jl = ~jl;
                cyc(logic'($urandom_range(0, 2) == 0), jl, logic'($urandom_range(0, 49) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
